plic_ctx0: RTL

- Platform-level interrupt controller for the single hart, context 0 (machine mode).
- Gathers up to 31 level-sensitive external interrupt sources and arbitrates them by priority.
- Drives a machine-external interrupt request into the core, alongside the CLINT's timer/software interrupt.
- Exposes a claim/complete register file on the same data-bus read/write protocol as the CLINT; read responses are OR-muxed at the top level.

---
 rtl/plic_ctx0.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/plic_ctx0.sv
// Machine-mode PLIC context 0: level gateways, priority arbiter,
// claim/complete register file and registered external-interrupt request.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   IRQ[SRC_NUMS-1:0]  level interrupt lines, bit i = source ID i+1
//   RDEN/RIADDR        read request and address
//   RVALID/ROADDR/RDATA registered read response (region hits only)
//   WREN/WADDR/WDATA   single-cycle full-word write
//   INT_EN/INT_CODE    external interrupt pending, cause code 11
module plic_ctx0 #(
  parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
  parameter int          SRC_NUMS  = 8,
  parameter int          PRIO_BITS = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SRC_NUMS-1:0] IRQ,
  input  logic                RDEN,
  input  logic [31:0]         RIADDR,
  output logic [31:0]         ROADDR,
  output logic                RVALID,
  output logic [31:0]         RDATA,
  input  logic                WREN,
  input  logic [31:0]         WADDR,
  input  logic [31:0]         WDATA,
  output logic                INT_EN,
  output logic [3:0]          INT_CODE
);

  localparam logic [31:0] REGION_MASK = 32'hFC00_0000;
  localparam logic [25:0] OFF_PEND    = 26'h000_1000;
  localparam logic [25:0] OFF_EN      = 26'h000_2000;
  localparam logic [25:0] OFF_THR     = 26'h020_0000;
  localparam logic [25:0] OFF_CLAIM   = 26'h020_0004;

  logic [PRIO_BITS-1:0] r_prio [1:SRC_NUMS];
  logic [SRC_NUMS:1]    r_en;
  logic [SRC_NUMS:1]    r_pend;
  logic [SRC_NUMS:1]    r_insvc;
  logic [SRC_NUMS:1]    r_irq_q;
  logic [PRIO_BITS-1:0] r_thr;
  logic                 r_rvalid;
  logic [31:0]          r_roaddr;
  logic [31:0]          r_rdata;
  logic                 r_int_en;
  logic [3:0]           r_int_code;

  logic                 w_rhit;
  logic                 w_whit;
  logic [25:0]          w_roff;
  logic [25:0]          w_woff;
  logic                 w_claim;
  logic                 w_cmpl;
  logic [4:0]           w_cid;
  logic [4:0]           w_max_id;
  logic [PRIO_BITS-1:0] w_max_prio;
  logic                 w_req;
  logic [31:0]          w_rval;
  logic                 w_unused;

  assign w_roff  = RIADDR[25:0];
  assign w_woff  = WADDR[25:0];
  assign w_rhit  = RDEN && ((RIADDR & REGION_MASK) == BASE_ADDR);
  assign w_whit  = WREN && ((WADDR & REGION_MASK) == BASE_ADDR);
  assign w_claim = w_rhit && (w_roff == OFF_CLAIM);
  assign w_cmpl  = w_whit && (w_woff == OFF_CLAIM);
  assign w_cid   = WDATA[4:0];
  assign w_unused = ^WDATA;

  // Strict '>' against a zero seed: priority 0 never wins and
  // equal priorities keep the lowest ID found first.
  always_comb begin
    w_max_id   = '0;
    w_max_prio = '0;
    for (int n = 1; n <= SRC_NUMS; n++) begin
      if (r_pend[n] && r_en[n] && (r_prio[n] > w_max_prio)) begin
        w_max_id   = 5'(n);
        w_max_prio = r_prio[n];
      end
    end
  end

  assign w_req = (w_max_id != 5'd0) && (w_max_prio > r_thr);

  always_comb begin
    w_rval = '0;
    if (w_roff == OFF_PEND) begin
      w_rval = 32'({r_pend, 1'b0});
    end else if (w_roff == OFF_EN) begin
      w_rval = 32'({r_en, 1'b0});
    end else if (w_roff == OFF_THR) begin
      w_rval = 32'(r_thr);
    end else if (w_roff == OFF_CLAIM) begin
      w_rval = 32'(w_max_id);
    end else begin
      for (int n = 1; n <= SRC_NUMS; n++) begin
        if (w_roff == 26'(4 * n)) begin
          w_rval = 32'(r_prio[n]);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 1; n <= SRC_NUMS; n++) begin
        r_prio[n] <= '0;
      end
      r_en       <= '0;
      r_pend     <= '0;
      r_insvc    <= '0;
      r_irq_q    <= '0;
      r_thr      <= '0;
      r_rvalid   <= 1'b0;
      r_roaddr   <= '0;
      r_rdata    <= '0;
      r_int_en   <= 1'b0;
      r_int_code <= 4'd0;
    end else begin
      r_irq_q <= IRQ;
      if (w_whit && (w_woff == OFF_EN)) begin
        r_en <= WDATA[SRC_NUMS:1];
      end
      if (w_whit && (w_woff == OFF_THR)) begin
        r_thr <= WDATA[PRIO_BITS-1:0];
      end
      for (int n = 1; n <= SRC_NUMS; n++) begin
        if (w_whit && (w_woff == 26'(4 * n))) begin
          r_prio[n] <= WDATA[PRIO_BITS-1:0];
        end
        // A claim overrides both a fresh gateway request and a
        // same-cycle completion of the same source.
        if (w_claim && (w_max_id == 5'(n))) begin
          r_pend[n]  <= 1'b0;
          r_insvc[n] <= 1'b1;
        end else begin
          if (r_irq_q[n] && !r_insvc[n]) begin
            r_pend[n] <= 1'b1;
          end
          if (w_cmpl && (w_cid == 5'(n)) && r_en[n]) begin
            r_insvc[n] <= 1'b0;
          end
        end
      end
      r_int_en   <= w_req;
      r_int_code <= w_req ? 4'd11 : 4'd0;
      r_rvalid   <= w_rhit;
      if (w_rhit) begin
        r_roaddr <= RIADDR;
        r_rdata  <= w_rval;
      end
    end
  end

  assign RVALID   = r_rvalid;
  assign ROADDR   = r_roaddr;
  assign RDATA    = r_rdata;
  assign INT_EN   = r_int_en;
  assign INT_CODE = r_int_code;

endmodule
